aes_inv_addkey_mixcol: RTL and testbench
========================================

// Module: aes_inv_addkey_mixcol
// PURPOSE
//  Decryption round stage that runs AddRoundKey, then InvMixColumns.
//  Per round: latches the post-InvSubBytes state and the round key, XORs them,
//  then applies InvMixColumns column-serially, COLS_PER_CYCLE columns per clock.
//  Has a valid/ready handshake on both sides. in_last bypasses InvMixColumns for the final round.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns mixed per clock; legal values 1, 2, 4; N = 4/COLS_PER_CYCLE mix cycles
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    in_state/in_key/in_last valid
//  in_ready   out  1    stage can accept (IDLE only)
//  in_state   in   128  round state; column c = [127-32c -: 32], row 0 in MSB byte
//  in_key     in   128  round key, same byte order
//  in_last    in   1    1 = final round: output state^key, no InvMixColumns
//  out_valid  out  1    out_state valid; held until out_ready
//  out_ready  in   1    downstream accepts
//  out_state  out  128  result, same byte order
//  busy       out  1    high in MIX or HOLD
// BEHAVIOUR
//  Reset
//  - Sampled at clk edge while rst=1.
//  - Result: FSM=IDLE, col_cnt=0, sr=0, out_valid=0, busy=0, in_ready=1 (after the edge).
//  - out_state=0. Reset has priority over every handshake in the same cycle.
//  IDLE
//  - in_ready=1.
//  - On in_valid&&in_ready at edge k: sr<=in_state^in_key, last_q<=in_last, col_cnt<=0.
//  - Then go to HOLD if in_last, else go to MIX.
//  MIX
//  - Each edge replaces columns col_cnt..col_cnt+COLS_PER_CYCLE-1 of sr with their InvMixColumns value.
//  - col_cnt increments by COLS_PER_CYCLE, wrapping 2-bit.
//  - The edge that mixes column 3 moves the FSM to HOLD.
//  - Columns not yet mixed are never modified.
//  HOLD
//  - out_valid=1 and out_state=sr.
//  - out_state stays stable while out_ready=0.
//  - On out_ready the FSM returns to IDLE; out_valid drops after that edge.
//  Handshake
//  - in_ready=0 in MIX and HOLD, so no new block is accepted until the output handshake completes.
//  - in_valid is ignored outside IDLE.
//  Latency (acceptance at edge k)
//  - last: out_valid after edge k.
//  - non-last: out_valid after edge k+N.
//  - Minimum spacing between acceptances: N+2 cycles (last: 2).
//  InvMixColumns on column bytes (a0..a3), GF(2^8) with poly 0x11B
//  - b0=0e*a0^0b*a1^0d*a2^09*a3
//  - b1=09*a0^0e*a1^0b*a2^0d*a3
//  - b2=0d*a0^09*a1^0e*a2^0b*a3
//  - b3=0b*a0^0d*a1^09*a2^0e*a3
//  - Built from xtime chains, all 8-bit, no overflow beyond the reduction.
//  Reset mid-operation (rst in MIX or HOLD)
//  - Block is discarded; no out_valid pulse.
//  - IDLE, in_ready=1 after that edge.
//  in_last change after acceptance: no effect (latched in last_q).
// TESTING
//  1. COLS=1, key=0, last=0, state=8e4da1bc_9fdc589d_01010101_c6c6c6c6
//     -> out=db135345_f20a225c_01010101_c6c6c6c6, out_valid after edge k+4.
//  2. key=state (any), last=0 -> out=0; repeat with COLS_PER_CYCLE=2 and 4
//     -> out_valid after edge k+2 and k+1 respectively.
//  3. last=1, state=00112233_44556677_8899aabb_ccddeeff, key=000102..0f
//     -> out=00102030_40506070_8090a0b0_c0d0e0f0 after edge k.
//  4. Test 1 with out_ready=0 for 3 cycles in HOLD
//     -> out_valid, out_state, in_ready=0 stable; one transfer on out_ready.
//  5. rst=1 at second MIX cycle of test 1 -> no out_valid; in_ready=1 next cycle;
//     new block then yields correct result.
//  6. in_valid held high across the busy window -> exactly one acceptance per block.

Source files
------------

// File: rtl/aes_inv_addkey_mixcol.sv
// ---------------------------------------------------------------------------
// aes_inv_addkey_mixcol
//   Decryption round stage: AddRoundKey followed by InvMixColumns.
//   A block is latched as (in_state ^ in_key), then mixed column-serially,
//   COLS_PER_CYCLE columns per clock. Final rounds (in_last=1) skip the mix
//   and are presented on the output straight away.
//
// Parameters
//   COLS_PER_CYCLE : columns mixed per clock (1, 2 or 4); N = 4/COLS_PER_CYCLE
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous reset, active-high
//   in_valid   in   1    in_state/in_key/in_last valid
//   in_ready   out  1    stage can accept (IDLE only)
//   in_state   in   128  round state, column c = [127-32c -: 32], row 0 in MSB
//   in_key     in   128  round key, same byte order
//   in_last    in   1    final round: output state^key, no InvMixColumns
//   out_valid  out  1    out_state valid, held until out_ready
//   out_ready  in   1    downstream accepts
//   out_state  out  128  result, same byte order
//   busy       out  1    high while mixing or holding a result
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   valid never depends on ready; once out_valid is high it stays high and
//   out_state stays stable until the edge on which out_ready is sampled high.
// ---------------------------------------------------------------------------
module aes_inv_addkey_mixcol #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_key,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MIX  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Column-counter step; for COLS_PER_CYCLE=4 this truncates to 0, which is
   // the correct 2-bit wrap (the whole block is mixed in one edge).
   localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

   state_t       state_q;
   state_t       state_d;
   logic [127:0] sr;
   logic [1:0]   col_cnt;
   logic         accept;
   logic         mix_done;
   logic [3:0]   col_sel;
   logic [127:0] mixed;

   // ---------------------------------------------------------------------
   // GF(2^8) arithmetic, reduction polynomial 0x11B
   // ---------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a   [4];
      logic [7:0] m09 [4];
      logic [7:0] m0b [4];
      logic [7:0] m0d [4];
      logic [7:0] m0e [4];
      logic [7:0] x2, x4, x8;
      for (int r = 0; r < 4; r++) begin
         a[r]   = col[31-8*r -: 8];
         x2     = xtime(a[r]);
         x4     = xtime(x2);
         x8     = xtime(x4);
         m09[r] = x8 ^ a[r];
         m0b[r] = x8 ^ x2 ^ a[r];
         m0d[r] = x8 ^ x4 ^ a[r];
         m0e[r] = x8 ^ x4 ^ x2;
      end
      return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
              m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
              m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
              m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
   endfunction

   // InvMixColumns of every column of sr; only the selected window is
   // written back, so unmixed columns keep their AddRoundKey value.
   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mixed[127-32*c -: 32] = inv_mix_col(sr[127-32*c -: 32]);
   end

   always_comb begin
      col_sel = '0;
      for (int c = 0; c < 4; c++) begin
         col_sel[c] = (c >= int'(col_cnt)) && (c < int'(col_cnt) + COLS_PER_CYCLE);
      end
   end

   // True on the edge whose window includes column 3.
   assign mix_done = (int'(col_cnt) + COLS_PER_CYCLE) >= 4;

   // ---------------------------------------------------------------------
   // FSM: state register + next-state logic
   // ---------------------------------------------------------------------
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_HOLD);
   assign busy      = (state_q != ST_IDLE);
   assign out_state = sr;
   assign accept    = in_valid && in_ready;

   // The final-round flag is captured by the transition itself: an accepted
   // last block goes straight to HOLD, so later changes on in_last are moot.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = in_last ? ST_HOLD : ST_MIX;
         ST_MIX:  if (mix_done)  state_d = ST_HOLD;
         ST_HOLD: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr      <= '0;
         col_cnt <= 2'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sr      <= in_state ^ in_key;
            col_cnt <= 2'd0;
         end else if (state_q == ST_MIX) begin
            for (int c = 0; c < 4; c++) begin
               if (col_sel[c]) begin
                  sr[127-32*c -: 32] <= mixed[127-32*c -: 32];
               end
            end
            col_cnt <= col_cnt + STEP;
         end
      end
   end

endmodule

// File: tb/tb_aes_inv_addkey_mixcol.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_addkey_mixcol
//   Drives three instances (COLS_PER_CYCLE = 1, 2, 4) that share the data
//   inputs and reset but have their own handshake signals. Expected results
//   come from a shift-and-add GF(2^8) reference model or from known vectors,
//   are queued when a block is offered and popped when out_valid appears.
// ---------------------------------------------------------------------------
module tb_aes_inv_addkey_mixcol;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   in_valid;
   logic [2:0]   out_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         in_last;
   logic [2:0]   in_ready;
   logic [2:0]   out_valid;
   logic [2:0]   busy;
   logic [127:0] out_state [3];

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] exp_q[$];

   localparam logic [127:0] S1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] S3 = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] K3 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] E3 = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   aes_inv_addkey_mixcol #(.COLS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_state(in_state), .in_key(in_key), .in_last(in_last),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_state(out_state[0]), .busy(busy[0]));

   aes_inv_addkey_mixcol #(.COLS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_state(in_state), .in_key(in_key), .in_last(in_last),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_state(out_state[1]), .busy(busy[1]));

   aes_inv_addkey_mixcol #(.COLS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_state(in_state), .in_key(in_key), .in_last(in_last),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_state(out_state[2]), .busy(busy[2]));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [31:0] model_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
      return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
              gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
              gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
              gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
   endfunction

   function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                          input logic last);
      logic [127:0] s;
      s = st ^ key;
      if (!last) begin
         for (int c = 0; c < 4; c++) s[127-32*c -: 32] = model_col(s[127-32*c -: 32]);
      end
      return s;
   endfunction

   function automatic int mix_cycles(input int d);
      return (d == 0) ? 4 : (d == 1) ? 2 : 1;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- driver: one block through one instance ----------------
   task automatic run_block(input int d, input logic [127:0] st, input logic [127:0] key,
                            input logic last, input logic [127:0] expv, input int stall);
      int           lat_exp;
      int           j;
      logic [127:0] got;
      logic [127:0] want;
      lat_exp = last ? 0 : mix_cycles(d);
      @(negedge clk);
      n_checks++;
      if (in_ready[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL in_ready_idle dut%0d: got %b want 1", d, in_ready[d]);
      end
      in_state    = st;
      in_key      = key;
      in_last     = last;
      in_valid[d] = 1'b1;
      exp_q.push_back(expv);
      @(negedge clk);
      in_valid[d] = 1'b0;
      in_last     = ~last;   // must not affect the accepted block
      j = 0;
      while (out_valid[d] !== 1'b1 && j < 20) begin
         n_checks++;
         if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_window dut%0d: in_ready=%b busy=%b want 0/1", d, in_ready[d], busy[d]);
         end
         @(negedge clk);
         j++;
      end
      n_checks++;
      if (j != lat_exp || out_valid[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL latency dut%0d: got %0d cycles (valid=%b) want %0d", d, j, out_valid[d], lat_exp);
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      if (out_valid[d] !== 1'b1) return;
      got = out_state[d];
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL out_state dut%0d: got %h want %h", d, got, want);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid[d] !== 1'b1 || out_state[d] !== got || in_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable dut%0d: valid=%b state=%h in_ready=%b want 1/%h/0",
                     d, out_valid[d], out_state[d], in_ready[d], want);
         end
      end
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      n_checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
         n_fail++;
         $display("FAIL after_transfer dut%0d: valid=%b in_ready=%b busy=%b want 0/1/0",
                  d, out_valid[d], in_ready[d], busy[d]);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = '0; out_ready = '0;
      in_state = '0; in_key = '0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
             out_state[d] !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b busy=%b out=%h want 1/0/0/0",
                     d, in_ready[d], out_valid[d], busy[d], out_state[d]);
         end
      end
   endtask

   task automatic test_known_vector();
      run_block(0, S1, 128'h0, 1'b0, E1, 0);
   endtask

   task automatic test_key_equals_state();
      logic [127:0] st;
      for (int d = 0; d < 3; d++) begin
         st = rand128();
         run_block(d, st, st, 1'b0, 128'h0, 0);
      end
   endtask

   task automatic test_last_round();
      run_block(0, S3, K3, 1'b1, E3, 0);
      run_block(2, S3, K3, 1'b1, E3, 1);
   endtask

   task automatic test_output_stall();
      run_block(0, S1, 128'h0, 1'b0, E1, 3);
      run_block(1, S1, 128'h0, 1'b0, E1, 2);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_state = S1; in_key = '0; in_last = 1'b0; in_valid[0] = 1'b1;
      @(negedge clk);              // after acceptance edge: first MIX cycle
      in_valid[0] = 1'b0;
      @(negedge clk);              // second MIX cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid dut0: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                  out_valid[0], in_ready[0], busy[0]);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_novalid dut0: out_valid=%b want 0", out_valid[0]);
         end
      end
      run_block(0, S1, 128'h0, 1'b0, E1, 0);
   endtask

   task automatic test_back_to_back();
      logic [127:0] st, key, expv, want;
      int acc, outs, last_acc;
      st = rand128(); key = rand128();
      expv = model(st, key, 1'b0);
      acc = 0; outs = 0; last_acc = -1;
      @(negedge clk);
      in_state = st; in_key = key; in_last = 1'b0;
      in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      for (int e = 0; e < 18; e++) begin
         if (in_valid[0] && in_ready[0]) begin
            acc++;
            if (last_acc >= 0) begin
               n_checks++;
               if (e - last_acc != 6) begin
                  n_fail++;
                  $display("FAIL accept_spacing dut0: got %0d want 6", e - last_acc);
               end
            end
            last_acc = e;
            exp_q.push_back(expv);
         end
         if (out_valid[0] && out_ready[0]) begin
            outs++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            n_checks++;
            if (out_state[0] !== want) begin
               n_fail++;
               $display("FAIL b2b_out dut0: got %h want %h", out_state[0], want);
            end
         end
         @(negedge clk);
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b0;
      n_checks++;
      if (acc != 3 || outs != 3) begin
         n_fail++;
         $display("FAIL b2b_count dut0: accepts=%0d outputs=%0d want 3/3", acc, outs);
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [127:0] st, key;
      logic         last;
      int           d;
      for (int i = 0; i < 8; i++) begin
         d    = $urandom_range(0, 2);
         st   = rand128();
         key  = rand128();
         last = 1'($urandom_range(0, 1));
         run_block(d, st, key, last, model(st, key, last), $urandom_range(0, 2));
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_known_vector();
      test_key_equals_state();
      test_last_round();
      test_output_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
